// File: rtl/wb_clint.sv
// wb_clint: Wishbone core-local interruptor (msip, mtime, mtimecmp).
// Ports: clk_i/rst_i, wbs_* slave bus, xint_mtip_o/xint_msip_o to the core.

module wb_clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  localparam logic [15:0] PMAX = 16'(TICK_DIV - 1);

  logic [15:0] off;
  logic        hit_msip;
  logic        hit_cmp_lo;
  logic        hit_cmp_hi;
  logic        hit_mt_lo;
  logic        hit_mt_hi;
  logic        mapped;
  logic        accept;
  logic        wr;
  logic        tick;
  logic [31:0] rd_val;
  logic        msip_q;
  logic [15:0] presc_q;
  logic [63:0] mtime_q;
  logic [63:0] mtcmp_q;
  logic        unused_addr;

  assign off         = wbs_addr_i[15:0];
  assign unused_addr = ^wbs_addr_i[31:16];

  // Exact 16-bit match, so any misaligned
  // offset falls through as unmapped.
  always_comb begin
    hit_msip   = 1'b0;
    hit_cmp_lo = 1'b0;
    hit_cmp_hi = 1'b0;
    hit_mt_lo  = 1'b0;
    hit_mt_hi  = 1'b0;
    unique case (off)
      16'h0000: hit_msip   = 1'b1;
      16'h4000: hit_cmp_lo = 1'b1;
      16'h4004: hit_cmp_hi = 1'b1;
      16'hBFF8: hit_mt_lo  = 1'b1;
      16'hBFFC: hit_mt_hi  = 1'b1;
      default: ;
    endcase
  end

  assign mapped = hit_msip | hit_cmp_lo | hit_cmp_hi
                | hit_mt_lo | hit_mt_hi;

  // The pending response blocks a new accept,
  // so responses are never back to back.
  assign accept = wbs_cyc_i & wbs_stb_i
                & ~wbs_ack_o & ~wbs_err_o;
  assign wr     = accept & wbs_we_i & mapped;

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_msip:   rd_val = {31'b0, msip_q};
      hit_cmp_lo: rd_val = mtcmp_q[31:0];
      hit_cmp_hi: rd_val = mtcmp_q[63:32];
      hit_mt_lo:  rd_val = mtime_q[31:0];
      hit_mt_hi:  rd_val = mtime_q[63:32];
      default:    rd_val = '0;
    endcase
  end

  assign tick = (presc_q == PMAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= accept & mapped;
      wbs_err_o <= accept & ~mapped;
      wbs_dat_o <= (accept & mapped) ? rd_val : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      msip_q <= 1'b0;
    end else if (wr & hit_msip & wbs_sel_i[0]) begin
      msip_q <= wbs_dat_i[0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtcmp_q <= '1;
    end else begin
      if (wr & hit_cmp_lo)
        mtcmp_q[31:0] <= merge(mtcmp_q[31:0],
                               wbs_dat_i, wbs_sel_i);
      if (wr & hit_cmp_hi)
        mtcmp_q[63:32] <= merge(mtcmp_q[63:32],
                                wbs_dat_i, wbs_sel_i);
    end
  end

  // A bus write to either half wins over the
  // tick; the other half holds with no carry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q <= '0;
    end else if (wr & hit_mt_lo) begin
      mtime_q[31:0] <= merge(mtime_q[31:0],
                             wbs_dat_i, wbs_sel_i);
    end else if (wr & hit_mt_hi) begin
      mtime_q[63:32] <= merge(mtime_q[63:32],
                              wbs_dat_i, wbs_sel_i);
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xint_mtip_o <= 1'b0;
    end else begin
      xint_mtip_o <= (mtime_q >= mtcmp_q);
    end
  end

  assign xint_msip_o = msip_q;

endmodule
